// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared state encoding, 640x480 timing constants and CRC constants for vga_timing_decoder
package vga_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_MEASURE = 2'd2,
        ST_LOCKED  = 2'd3
    } vga_state_t;

    localparam int VGA_H_TOTAL      = 800;
    localparam int VGA_V_TOTAL      = 525;
    localparam int VGA_H_ACTIVE     = 640;
    localparam int VGA_V_ACTIVE     = 480;
    localparam int VGA_H_SYNC_START = 656;
    localparam int VGA_V_SYNC_START = 490;

    // period counters saturate well above any legal 10-bit timing
    localparam int MEAS_W = 12;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    function automatic logic [15:0] crc16_px(input logic [15:0] crc, input logic [23:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 23; i >= 0; i--) begin
            if (c[15] ^ data[i]) begin
                c = {c[14:0], 1'b0} ^ CRC16_POLY;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/vga_rx_sync.sv
// rtl/vga_rx_sync.sv - two-flop synchronizers, pixel strobe and per-pixel sync edge detection
module vga_rx_sync (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vga_clk,
    input  logic        hs,
    input  logic        vs,
    input  logic        blank,
    input  logic [23:0] rgb,
    input  logic        err_clr,
    output logic        pix_strobe,
    output logic        hs_fall,
    output logic        vs_fall,
    output logic        pix_blank,
    output logic [23:0] pix_rgb,
    output logic        clr_pulse
);

    // bit layout: {vga_clk, hs, vs, blank, err_clr, rgb}
    localparam int W = 29;
    localparam logic [W-1:0] IDLE = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h0};

    logic [W-1:0] meta;
    logic [W-1:0] sync;
    logic         clk_q;
    logic         hs_q;
    logic         vs_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta  <= IDLE;
            sync  <= IDLE;
            clk_q <= 1'b0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
        end else begin
            meta  <= {vga_clk, hs, vs, blank, err_clr, rgb};
            sync  <= meta;
            clk_q <= sync[28];
            // sync levels are only tracked at strobes so edges land on a pixel boundary
            if (pix_strobe) begin
                hs_q <= sync[27];
                vs_q <= sync[26];
            end
        end
    end

    assign pix_strobe = sync[28] & ~clk_q;
    assign hs_fall    = pix_strobe & hs_q & ~sync[27];
    assign vs_fall    = pix_strobe & vs_q & ~sync[26];
    assign pix_blank  = sync[25];
    assign clr_pulse  = sync[24];
    assign pix_rgb    = sync[23:0];

endmodule

// File: rtl/vga_timing_decoder.sv
// rtl/vga_timing_decoder.sv - recovers pixel/line coordinates and lock from VGA sync; frame CRC via VGA_TIMING_DECODER_CRC_EN
module vga_timing_decoder
    import vga_pkg::*;
#(
    parameter int H_TOTAL      = VGA_H_TOTAL,
    parameter int V_TOTAL      = VGA_V_TOTAL,
    parameter int H_ACTIVE     = VGA_H_ACTIVE,
    parameter int V_ACTIVE     = VGA_V_ACTIVE,
    parameter int H_SYNC_START = VGA_H_SYNC_START,
    parameter int V_SYNC_START = VGA_V_SYNC_START
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        VGA_clk,
    input  logic        hs,
    input  logic        vs,
    input  logic        blank,
    input  logic [7:0]  Red,
    input  logic [7:0]  Green,
    input  logic [7:0]  Blue,
    input  logic        err_clr,
    output logic [9:0]  RxX,
    output logic [9:0]  RxY,
    output logic        rx_valid,
    output logic        locked,
    output logic        frame_done,
    output logic [7:0]  frame_cnt,
    output logic        err_h,
    output logic        err_v,
    output logic        err_blank
`ifdef VGA_TIMING_DECODER_CRC_EN
    ,
    output logic [15:0] frame_crc
`endif
);

    localparam logic [9:0]        H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]        V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]        H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0]        V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]        H_SS     = 10'(H_SYNC_START);
    localparam logic [9:0]        V_SS     = 10'(V_SYNC_START);
    localparam logic [MEAS_W-1:0] H_PERIOD = MEAS_W'(H_TOTAL);
    localparam logic [MEAS_W-1:0] V_PERIOD = MEAS_W'(V_TOTAL);

    logic              strobe;
    logic              hs_fall;
    logic              vs_fall;
    logic              pix_blank;
    logic [23:0]       pix_rgb;
    logic              clr_pulse;

    vga_state_t        state;
    logic              good_frame;
    logic [9:0]        x_nxt;
    logic [9:0]        y_nxt;
    logic [MEAS_W-1:0] h_meas;
    logic [MEAS_W-1:0] v_meas;
    logic              visible;
    logic              h_bad;
    logic              v_bad;

    vga_rx_sync u_sync (
        .clk        (Clk),
        .rst_n      (Reset),
        .vga_clk    (VGA_clk),
        .hs         (hs),
        .vs         (vs),
        .blank      (blank),
        .rgb        ({Red, Green, Blue}),
        .err_clr    (err_clr),
        .pix_strobe (strobe),
        .hs_fall    (hs_fall),
        .vs_fall    (vs_fall),
        .pix_blank  (pix_blank),
        .pix_rgb    (pix_rgb),
        .clr_pulse  (clr_pulse)
    );

    // coordinate of the pixel carried by the current strobe
    always_comb begin
        x_nxt = RxX;
        y_nxt = RxY;
        if (strobe) begin
            if (hs_fall) begin
                x_nxt = H_SS;
            end else if (RxX == H_LAST) begin
                x_nxt = 10'd0;
            end else begin
                x_nxt = RxX + 10'd1;
            end
        end
        if (vs_fall) begin
            y_nxt = V_SS;
        end else if (hs_fall) begin
            y_nxt = (RxY == V_LAST) ? 10'd0 : RxY + 10'd1;
        end
    end

    assign visible = (x_nxt < H_ACT) && (y_nxt < V_ACT);
    assign h_bad   = hs_fall && (h_meas != H_PERIOD);
    assign v_bad   = vs_fall && (v_meas != V_PERIOD);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            RxX    <= 10'd0;
            RxY    <= 10'd0;
            h_meas <= '0;
            v_meas <= '0;
        end else begin
            RxX <= x_nxt;
            RxY <= y_nxt;
            // the strobe carrying the hs edge is the first pixel of the new line
            if (hs_fall) begin
                h_meas <= MEAS_W'(1);
            end else if (strobe && h_meas != '1) begin
                h_meas <= h_meas + 1'b1;
            end
            if (vs_fall) begin
                v_meas <= hs_fall ? MEAS_W'(1) : '0;
            end else if (hs_fall && v_meas != '1) begin
                v_meas <= v_meas + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= ST_SEARCH;
            good_frame <= 1'b0;
            locked     <= 1'b0;
            rx_valid   <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= 8'd0;
            err_h      <= 1'b0;
            err_v      <= 1'b0;
            err_blank  <= 1'b0;
        end else begin
            rx_valid   <= 1'b0;
            frame_done <= 1'b0;
            if (clr_pulse) begin
                err_h     <= 1'b0;
                err_v     <= 1'b0;
                err_blank <= 1'b0;
            end
            case (state)
                ST_SEARCH: begin
                    if (hs_fall) begin
                        state <= ST_WAIT_VS;
                    end
                end
                ST_WAIT_VS: begin
                    if (vs_fall) begin
                        state      <= ST_MEASURE;
                        good_frame <= 1'b0;
                    end
                end
                ST_MEASURE: begin
                    if (h_bad || v_bad) begin
                        state <= ST_SEARCH;
                    end else if (vs_fall) begin
                        if (good_frame) begin
                            state  <= ST_LOCKED;
                            locked <= 1'b1;
                        end else begin
                            good_frame <= 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    rx_valid <= strobe & visible;
                    // error sets are written after the clear so a coincident event keeps the flag
                    if (strobe && (pix_blank != visible)) begin
                        err_blank <= 1'b1;
                    end
                    if (h_bad) begin
                        err_h <= 1'b1;
                    end
                    if (v_bad) begin
                        err_v <= 1'b1;
                    end
                    if (vs_fall) begin
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 8'd1;
                    end
                    if (h_bad || v_bad) begin
                        state  <= ST_SEARCH;
                        locked <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_SEARCH;
                    locked <= 1'b0;
                end
            endcase
        end
    end

`ifdef VGA_TIMING_DECODER_CRC_EN
    logic [15:0] crc_acc;
    logic [23:0] rgb_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            crc_acc   <= CRC16_INIT;
            frame_crc <= 16'd0;
            rgb_q     <= 24'd0;
        end else begin
            if (strobe) begin
                rgb_q <= pix_rgb;
            end
            if (frame_done) begin
                frame_crc <= crc_acc;
                crc_acc   <= rx_valid ? crc16_px(CRC16_INIT, rgb_q) : CRC16_INIT;
            end else if (!locked) begin
                crc_acc <= CRC16_INIT;
            end else if (rx_valid) begin
                crc_acc <= crc16_px(crc_acc, rgb_q);
            end
        end
    end
`else
    logic unused_rgb;
    assign unused_rgb = ^pix_rgb;
`endif

endmodule

// File: tb/tb_vga_timing_decoder.sv
// tb/tb_vga_timing_decoder.sv - directed scoreboard bench for vga_timing_decoder on a reduced raster
module tb_vga_timing_decoder;

    localparam int HT  = 40;
    localparam int VT  = 20;
    localparam int HA  = 24;
    localparam int VA  = 12;
    localparam int HSS = 28;
    localparam int VSS = 14;

    logic        Clk     = 1'b0;
    logic        Reset   = 1'b0;
    logic        VGA_clk = 1'b0;
    logic        hs      = 1'b1;
    logic        vs      = 1'b1;
    logic        blank   = 1'b0;
    logic [7:0]  Red     = 8'h00;
    logic [7:0]  Green   = 8'h00;
    logic [7:0]  Blue    = 8'h00;
    logic        err_clr = 1'b0;
    logic [9:0]  RxX;
    logic [9:0]  RxY;
    logic        rx_valid;
    logic        locked;
    logic        frame_done;
    logic [7:0]  frame_cnt;
    logic        err_h;
    logic        err_v;
    logic        err_blank;
`ifdef VGA_TIMING_DECODER_CRC_EN
    logic [15:0] frame_crc;
`endif

    int          checks    = 0;
    int          failures  = 0;
    int          rxv_count = 0;
    logic        sb_en     = 1'b0;
    logic [19:0] sb_q[$];
    logic [19:0] exp_xy;
    logic        err_h_q     = 1'b0;
    logic        err_blank_q = 1'b0;

    vga_timing_decoder #(
        .H_TOTAL      (HT),
        .V_TOTAL      (VT),
        .H_ACTIVE     (HA),
        .V_ACTIVE     (VA),
        .H_SYNC_START (HSS),
        .V_SYNC_START (VSS)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .VGA_clk    (VGA_clk),
        .hs         (hs),
        .vs         (vs),
        .blank      (blank),
        .Red        (Red),
        .Green      (Green),
        .Blue       (Blue),
        .err_clr    (err_clr),
        .RxX        (RxX),
        .RxY        (RxY),
        .rx_valid   (rx_valid),
        .locked     (locked),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .err_h      (err_h),
        .err_v      (err_v),
`ifdef VGA_TIMING_DECODER_CRC_EN
        .frame_crc  (frame_crc),
`endif
        .err_blank  (err_blank)
    );

    always #10 Clk = ~Clk;

    // pixel clock offset 5 ns from every Clk edge
    initial begin
        #5;
        forever #20 VGA_clk = ~VGA_clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

`ifdef VGA_TIMING_DECODER_CRC_EN
    function automatic logic [15:0] golden_zero_crc();
        logic [15:0] c;
        logic [23:0] d;
        c = 16'hFFFF;
        d = 24'h0;
        for (int p = 0; p < HA * VA; p++) begin
            for (int b = 23; b >= 0; b--) begin
                c = (c[15] ^ d[b]) ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction
`endif

    always @(negedge Clk) begin
        if (rx_valid) begin
            rxv_count++;
            if (sb_en) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 32'(sb_q.size()), 32'd1);
                end else begin
                    exp_xy = sb_q.pop_front();
                    check("rx_xy", 32'({RxX, RxY}), 32'(exp_xy));
                end
            end
        end
        if (err_h && !err_h_q) check("err_h_drops_lock", 32'(locked), 32'd0);
        if (err_blank && !err_blank_q) check("err_blank_keeps_lock", 32'(locked), 32'd1);
        err_h_q     = err_h;
        err_blank_q = err_blank;
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rxx"}, 32'(RxX), 32'd0);
        check({tag, "_rxy"}, 32'(RxY), 32'd0);
        check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
        check({tag, "_errs"}, 32'({err_h, err_v, err_blank}), 32'd0);
    endtask

    // one frame from line 0; -1 disables each injected event
    task automatic drive_frame(input int short_line, input int bx, input int by,
                               input int clr_line, input int rst_line, input int rel_line);
        for (int vc = 0; vc < VT; vc++) begin
            for (int hc = 0; hc < HT; hc++) begin
                if (vc == short_line && hc == HT - 1) continue;
                @(negedge VGA_clk);
                hs    = !(hc >= HSS && hc < HSS + 4);
                vs    = !(vc >= VSS && vc < VSS + 2);
                blank = (hc < HA && vc < VA) || (hc == bx && vc == by);
                if (sb_en && hc < HA && vc < VA) sb_q.push_back({10'(hc), 10'(vc)});
                if (vc == clr_line && hc == 0) begin
                    @(posedge Clk);
                    #1 err_clr = 1'b1;
                    @(posedge Clk);
                    #1 err_clr = 1'b0;
                end
                if (vc == rst_line && hc == 5) begin
                    #1 Reset = 1'b0;
                    #1;
                    check_reset_outputs("midframe_reset");
                end
                if (vc == rel_line && hc == 0) Reset = 1'b1;
            end
        end
        @(negedge Clk);
    endtask

    initial begin
        repeat (4) @(posedge Clk);
        #1;
        check_reset_outputs("reset");
        Reset = 1'b1;

        drive_frame(-1, -1, -1, -1, -1, -1);
        check("lock_frame_a", 32'(locked), 32'd0);
        drive_frame(-1, -1, -1, -1, -1, -1);
        check("lock_frame_b", 32'(locked), 32'd0);
        drive_frame(-1, -1, -1, -1, -1, -1);
        check("lock_frame_c", 32'(locked), 32'd1);
        check("frame_cnt_at_lock", 32'(frame_cnt), 32'd0);

        sb_en = 1'b1;
        rxv_count = 0;
        drive_frame(-1, -1, -1, -1, -1, -1);
        check("frame_cnt_after_d", 32'(frame_cnt), 32'd1);
        check("rx_valid_count_d", 32'(rxv_count), 32'(HA * VA));
        check("sb_drained_d", 32'(sb_q.size()), 32'd0);
`ifdef VGA_TIMING_DECODER_CRC_EN
        check("frame_crc_d", 32'(frame_crc), 32'(golden_zero_crc()));
`endif

        drive_frame(-1, 30, 3, -1, -1, -1);
        check("err_blank_set", 32'(err_blank), 32'd1);
        check("blank_keeps_lock", 32'(locked), 32'd1);
        check("err_h_clean_e", 32'(err_h), 32'd0);
        check("frame_cnt_after_e", 32'(frame_cnt), 32'd2);
        check("sb_drained_e", 32'(sb_q.size()), 32'd0);
`ifdef VGA_TIMING_DECODER_CRC_EN
        check("frame_crc_repeat", 32'(frame_crc), 32'(golden_zero_crc()));
`endif
        sb_en = 1'b0;

        drive_frame(-1, -1, -1, 0, -1, -1);
        check("err_blank_cleared", 32'(err_blank), 32'd0);
        check("lock_frame_f", 32'(locked), 32'd1);
        check("frame_cnt_after_f", 32'(frame_cnt), 32'd3);

        drive_frame(5, -1, -1, -1, -1, -1);
        check("err_h_set", 32'(err_h), 32'd1);
        check("short_line_unlock", 32'(locked), 32'd0);
        check("frame_cnt_held", 32'(frame_cnt), 32'd3);
        drive_frame(-1, -1, -1, -1, -1, -1);
        check("relock_frame_h", 32'(locked), 32'd0);
        drive_frame(-1, -1, -1, -1, -1, -1);
        check("relock_frame_i", 32'(locked), 32'd1);
        check("err_h_sticky", 32'(err_h), 32'd1);

        sb_en = 1'b1;
        rxv_count = 0;
        drive_frame(-1, -1, -1, 0, -1, -1);
        check("err_h_cleared", 32'(err_h), 32'd0);
        check("err_blank_clean_j", 32'(err_blank), 32'd0);
        check("frame_cnt_after_j", 32'(frame_cnt), 32'd4);
        check("rx_valid_count_j", 32'(rxv_count), 32'(HA * VA));
        check("sb_drained_j", 32'(sb_q.size()), 32'd0);
        sb_en = 1'b0;

        drive_frame(-1, -1, -1, -1, 8, 12);
        check("post_reset_locked", 32'(locked), 32'd0);
        check("post_reset_frame_cnt", 32'(frame_cnt), 32'd0);
        drive_frame(-1, -1, -1, -1, -1, -1);
        check("post_reset_measure", 32'(locked), 32'd0);
        drive_frame(-1, -1, -1, -1, -1, -1);
        check("post_reset_relock", 32'(locked), 32'd1);
        check("post_reset_frame_cnt_l", 32'(frame_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_decoder.md
VGA_TIMING_DECODER -- requirements
Module: vga_timing_decoder

Interface
REQ-001 Param H_TOTAL, default 800, pixels per line.
REQ-002 Param V_TOTAL, default 525, lines per frame.
REQ-003 Param H_ACTIVE / V_ACTIVE, default 640 / 480, visible pixels / lines.
REQ-004 Param H_SYNC_START / V_SYNC_START, default 656 / 490, pixel / line index where the sync pulse begins.
REQ-005 Clk  in  1  50 MHz system clock; sole clock; all state on rising edge.
REQ-006 Reset  in  1  asynchronous, active-low reset.
REQ-007 VGA_clk  in  1  25 MHz pixel clock from the video source; sampled as data, never used as a clock.
REQ-008 hs, vs  in  1 each  horizontal / vertical sync, active low.
REQ-009 blank  in  1  active-low blanking indicator.
REQ-010 Red, Green, Blue  in  8 each  pixel colour.
REQ-011 err_clr  in  1  single-cycle pulse; clears sticky error flags.
REQ-012 RxX, RxY  out  10 each  recovered pixel / line coordinate.
REQ-013 rx_valid  out  1  one-Clk pulse per visible pixel while locked.
REQ-014 locked  out  1  timing lock indicator.
REQ-015 frame_done  out  1  one-Clk pulse at each vs falling edge while locked.
REQ-016 frame_cnt  out  8  locked-frame counter, wraps 255->0.
REQ-017 err_h, err_v, err_blank  out  1 each  sticky error flags.

Function
REQ-018 All inputs except Reset SHALL pass a 2-flop synchronizer before use; pixel strobe = rising edge of synchronized VGA_clk (one Clk pulse per pixel).
REQ-019 Pixel counter SHALL load H_SYNC_START on synchronized hs falling edge, else increment per strobe, wrapping H_TOTAL-1 -> 0.
REQ-020 Line counter SHALL load V_SYNC_START on vs falling edge, else increment on each hs falling edge, wrapping V_TOTAL-1 -> 0; vs and hs falling together: vs load wins.
REQ-021 Line period SHALL be measured as strobes between hs falling edges; frame period as hs falls between vs falling edges.
REQ-022 States: SEARCH (reset), WAIT_VS, MEASURE, LOCKED.
REQ-023 SEARCH -> WAIT_VS on first hs falling edge; WAIT_VS -> MEASURE on next vs falling edge.
REQ-024 MEASURE -> LOCKED after two consecutive frames with every line period = H_TOTAL and frame period = V_TOTAL; any mismatch -> SEARCH.
REQ-025 In LOCKED, line period != H_TOTAL SHALL set err_h; frame period != V_TOTAL SHALL set err_v; either SHALL return FSM to SEARCH next cycle.
REQ-026 In LOCKED, on each strobe, blank SHALL equal (RxX<H_ACTIVE && RxY<V_ACTIVE); mismatch sets err_blank without losing lock.
REQ-027 locked = 1 only in LOCKED; rx_valid = strobe & locked & RxX<H_ACTIVE & RxY<V_ACTIVE, registered, one Clk after strobe.
REQ-028 err_clr SHALL clear all sticky flags; an error event in the same cycle SHALL win (flag stays set).
REQ-029 frame_cnt SHALL increment with each frame_done; held (not cleared) on lock loss.

Reset
REQ-030 Reset asserted: FSM=SEARCH, RxX=RxY=0, counters/measurements=0, locked=rx_valid=frame_done=0, frame_cnt=0, all err flags=0, synchronizers=inactive (hs/vs/blank=1, VGA_clk=0).
REQ-031 Reset asserted mid-frame SHALL abort immediately; after release, relock requires full SEARCH sequence.

Configuration
REQ-032 Macro VGA_TIMING_DECODER_CRC_EN: when defined, a CRC-16/CCITT (init 0xFFFF) SHALL accumulate {Red,Green,Blue} on every rx_valid, output frame_crc (16 bits) latched at frame_done, reinitialised after latch; when undefined, frame_crc port and CRC logic SHALL be absent.

Structure
REQ-033 Package vga_pkg SHALL hold the FSM state enum, 640x480 timing constants, and the CRC polynomial constant.
REQ-034 One sub-module, vga_rx_sync, SHALL implement the synchronizers and pixel-strobe edge detect.

Verification
REQ-035 Drive standard 800x525 timing for 3 frames -> locked=1 at second vs fall after MEASURE entry, frame_cnt=1 after next frame.
REQ-036 Locked; source pixel (hc=100, vc=200) -> RxX=100, RxY=200, rx_valid pulses 640x480=307200 times per frame.
REQ-037 Locked; one line shortened to 799 pixels -> err_h=1, locked=0 next cycle, relock after 2 good frames.
REQ-038 Locked; blank forced high at (700,10) -> err_blank=1, locked stays 1; err_clr pulse -> err_blank=0.
REQ-039 Reset low during line 300 -> all outputs 0 immediately; release -> state SEARCH, locked=0.
REQ-040 CRC_EN defined, constant colour 0x000000 frame -> frame_crc equals golden model value, repeated identically next frame.
